dmem_dump_responder: RTL

- Data-memory responder for the processor's data-memory port: DM_writeData, DM_addr, DM_writeEnable and dump.
- Stores 64-bit words and returns combinational read data to the datapath.
- A rising edge on dump starts a sequential dump engine. It streams every word, with its byte address, over a valid/ready interface to a bench monitor or debug sink.

---
 rtl/dmem_dump_responder_if.sv | 27 ++
 rtl/dmem_dump_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dmem_dump_responder_if.sv
// Data-memory port plus dump stream of dmem_dump_responder, bundled as one interface.
// master = datapath/debug-sink side, slave = the responder.
interface dmem_dump_responder_if #(
    parameter int N = 64
);
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic [N-1:0] DM_readData;
    logic         dump;
    logic         dump_valid;
    logic         dump_ready;
    logic [N-1:0] dump_addr;
    logic [N-1:0] dump_data;
    logic         dump_busy;
    logic         dump_done;

    modport master (
        output DM_addr, DM_writeData, DM_writeEnable, dump, dump_ready,
        input  DM_readData, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  DM_addr, DM_writeData, DM_writeEnable, dump, dump_ready,
        output DM_readData, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/dmem_dump_responder.sv
// Word-addressed data memory with combinational read and a rising-edge-triggered dump engine.
// Optional macro DMEM_DUMP_SKIP_ZERO_EN: the dump skips words that are zero.
module dmem_dump_responder #(
    parameter int N     = 64,
    parameter int DEPTH = 32
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    dmem_dump_responder_if.slave  bus,
    output logic [1:0]            dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q;
    logic [AW-1:0] idx_q;
    logic          dump_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  addr_q;
    logic [N-1:0]  data_q;
    logic [N-1:0]  mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic          start;
    logic          scan_skip;
    logic          unused_addr_bits;

    // Byte address -> word index; upper bits are ignored so addresses wrap.
    assign word_idx         = bus.DM_addr[AW+2:3];
    assign unused_addr_bits = ^{bus.DM_addr[N-1:AW+3], bus.DM_addr[2:0]};
    assign start            = bus.dump & ~dump_q;

`ifdef DMEM_DUMP_SKIP_ZERO_EN
    assign scan_skip = (mem_q[idx_q] == '0);
`else
    assign scan_skip = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.DM_writeEnable) begin
            mem_q[word_idx] <= bus.DM_writeData;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign bus.DM_readData = mem_q[word_idx];

    // Dump stream: a beat transfers on a rising edge where dump_valid and
    // dump_ready are both high; dump_valid/addr/data stay stable until then.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dump_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            dump_q <= bus.dump;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_skip) begin
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + AW'(1);
                        end
                    end else begin
                        data_q  <= mem_q[idx_q];
                        addr_q  <= N'({idx_q, 3'b000});
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (valid_q && bus.dump_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dump_valid = valid_q;
    assign bus.dump_addr  = addr_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_busy  = busy_q;
    assign bus.dump_done  = done_q;
    assign dbg_state_o    = state_q;

endmodule
